// File: rtl/seq_ctrl_pkg.sv
// Shared types and default parameter values for the serial pattern detector
// run-control block (seq_detect_ctrl) and its matcher (seq_pattern_match).
package seq_ctrl_pkg;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_WIN_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_pattern_match.sv
// Serial pattern matcher: PAT_W-1 bit history, fill count and compare.
// The newest bit is the LSB of the compare word, so the pattern MSB is the
// oldest (first received) bit. After a hit, non-overlap mode restarts the
// fill so no bit can be reused; overlap mode keeps the history in play.
module seq_pattern_match #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_accept,
   input  logic             i_bit,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic             i_overlap,
   output logic             o_match
);

   localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W - 1);

   logic [PAT_W-2:0] r_hist;
   logic [FW-1:0]    r_fill;
   logic [PAT_W-1:0] w_cand;
   logic             w_match;

   // Compare the history plus the current bit against the pattern
   always_comb begin
      w_cand  = {r_hist, i_bit};
      w_match = i_accept && (r_fill == FILL_FULL) && (w_cand == i_pattern);
   end

   assign o_match = w_match;

   // History shift and fill bookkeeping on accepted bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_accept) begin
         r_hist <= w_cand[PAT_W-2:0];
         if (w_match && !i_overlap)
            r_fill <= '0;
         else if (r_fill != FILL_FULL)
            r_fill <= r_fill + FW'(1);
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-control for the serial pattern detectors: arms a run with a latched
// configuration, steps the matcher on valid bits, counts matches and ends the
// run on target reached (done) or bit window exhausted (timeout).
// Optional build macro SEQ_CTRL_IRQ_EN adds a sticky irq (with irq_clr) that
// sets when the run enters DONE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no run active; counters hold the last run's values
// ST_RUN  | accepting bits; matcher and counters advance
// ST_DONE | run ended; done/timeout and counters held until start/abort
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int WIN_W = DEF_WIN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic             in_valid,
   input  logic             in_bit,
`ifdef SEQ_CTRL_IRQ_EN
   input  logic             irq_clr,
   output logic             irq,
`endif
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [WIN_W-1:0] bits_seen,
   output logic             done,
   output logic             timeout
);

   state_t           r_state;
   state_t           w_state_next;

   logic [PAT_W-1:0] r_pattern;
   logic             r_overlap;
   logic [CNT_W-1:0] r_target;
   logic [WIN_W-1:0] r_window;
   logic [CNT_W-1:0] r_match_cnt;
   logic [WIN_W-1:0] r_bits_seen;
   logic             r_done;
   logic             r_timeout;

   logic             w_start;
   logic             w_accept;
   logic             w_match;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [WIN_W-1:0] w_bits_inc;
   logic             w_hit_target;
   logic             w_hit_win;

   // Qualify start/accept; abort overrides both in the same cycle
   always_comb begin
      w_start      = start && !abort && (r_state != ST_RUN);
      w_accept     = (r_state == ST_RUN) && in_valid && !abort;
      w_cnt_inc    = r_match_cnt + CNT_W'(1);
      w_bits_inc   = r_bits_seen + WIN_W'(1);
      w_hit_target = w_match && (w_cnt_inc == r_target);
      w_hit_win    = (r_window != '0) && (w_bits_inc == r_window);
   end

   seq_pattern_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_start),
      .i_accept  (w_accept),
      .i_bit     (in_bit),
      .i_pattern (r_pattern),
      .i_overlap (r_overlap),
      .o_match   (w_match)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start)
                  w_state_next = (cfg_target == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
               if (w_accept && (w_hit_target || w_hit_win))
                  w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      busy  = (r_state == ST_RUN);
      match = w_match;
   end

   // Config latch, counters and end-of-run status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pattern   <= '0;
         r_overlap   <= 1'b0;
         r_target    <= '0;
         r_window    <= '0;
         r_match_cnt <= '0;
         r_bits_seen <= '0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else if (abort) begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_start) begin
         r_pattern   <= cfg_pattern;
         r_overlap   <= cfg_overlap;
         r_target    <= cfg_target;
         r_window    <= cfg_window;
         r_match_cnt <= '0;
         r_bits_seen <= '0;
         r_done      <= (cfg_target == '0);
         r_timeout   <= 1'b0;
      end else if (w_accept) begin
         r_bits_seen <= w_bits_inc;
         if (w_match)
            r_match_cnt <= w_cnt_inc;
         if (w_hit_target)
            r_done <= 1'b1;
         else if (w_hit_win)
            r_timeout <= 1'b1;
      end
   end

   assign match_cnt = r_match_cnt;
   assign bits_seen = r_bits_seen;
   assign done      = r_done;
   assign timeout   = r_timeout;

`ifdef SEQ_CTRL_IRQ_EN
   logic r_irq;

   // Sticky interrupt: set on entry to DONE, set beats clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_irq <= 1'b0;
      else if ((w_state_next == ST_DONE) && (r_state != ST_DONE))
         r_irq <= 1'b1;
      else if (irq_clr)
         r_irq <= 1'b0;
   end

   assign irq = r_irq;
`endif

endmodule
